// File: rtl/kim1_pkg.sv
// Shared constants, debounce state encoding and key-index decode helpers
// for the KIM-1 display/keypad block.
package kim1_pkg;

   localparam int NUM_DIGITS = 6;
   localparam int NUM_ROWS   = 3;
   localparam int NUM_COLS   = 7;
   localparam int NUM_KEYS   = NUM_ROWS * NUM_COLS;

   localparam logic [3:0] DIGIT_BASE = 4'd4;
   localparam logic [3:0] SEL_NONE   = 4'hF;

   typedef enum logic [1:0] {
      DB_IDLE = 2'd0,
      DB_PEND = 2'd1,
      DB_HELD = 2'd2
   } db_state_e;

   function automatic logic [1:0] key_row(input logic [4:0] idx);
      if (idx < 5'd7)       key_row = 2'd0;
      else if (idx < 5'd14) key_row = 2'd1;
      else                  key_row = 2'd2;
   endfunction

   // Column is idx - 7*row; the result is below 8, so mod-8 arithmetic is exact.
   function automatic logic [2:0] key_col(input logic [4:0] idx);
      logic [2:0] base;
      case (key_row(idx))
         2'd0:    base = 3'd0;
         2'd1:    base = 3'd7;
         default: base = 3'd6;
      endcase
      key_col = idx[2:0] - base;
   endfunction

endpackage

// File: rtl/kim1_key_debounce.sv
// Host key debouncer: a key (or release) is accepted only after it has been
// stable for DEBOUNCE_TICKS clk_en ticks; the last accepted key stays reported meanwhile.
module kim1_key_debounce
   import kim1_pkg::*;
#(
   parameter int DEBOUNCE_TICKS = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_en,
   input  logic       key_down,
   input  logic [4:0] key_idx,
   output logic       held,
   output logic [1:0] row,
   output logic [2:0] col
);

   localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_TICKS - 1);

   db_state_e     state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [5:0]    smp_q, smp_d;
   logic          held_q, held_d;
   logic [4:0]    key_q, key_d;
   logic          cur_valid;
   logic [5:0]    cur;

   // Out-of-range indices collapse onto the single "released" code.
   assign cur_valid = key_down && (key_idx < 5'(NUM_KEYS));
   assign cur       = {cur_valid, cur_valid ? key_idx : 5'd0};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      smp_d   = smp_q;
      held_d  = held_q;
      key_d   = key_q;
      if (cur != smp_q) begin
         smp_d   = cur;
         cnt_d   = '0;
         state_d = DB_PEND;
      end else begin
         case (state_q)
            DB_PEND: begin
               if (clk_en) begin
                  if (cnt_q == CNT_LAST) begin
                     cnt_d = '0;
                     if (smp_q[5]) begin
                        state_d = DB_HELD;
                        held_d  = 1'b1;
                        key_d   = smp_q[4:0];
                     end else begin
                        state_d = DB_IDLE;
                        held_d  = 1'b0;
                     end
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= DB_IDLE;
         cnt_q   <= '0;
         smp_q   <= '0;
         held_q  <= 1'b0;
         key_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         smp_q   <= smp_d;
         held_q  <= held_d;
         key_q   <= key_d;
      end
   end

   assign held = held_q;
   assign row  = key_row(key_q);
   assign col  = key_col(key_q);

endmodule

// File: rtl/kim1_display_keypad.sv
// KIM-1 multiplexed display to static image converter plus keypad matrix scan.
// Optional macro KIM1_TTY_EN routes a synchronized tty_rx onto pa_i[7].
module kim1_display_keypad
   import kim1_pkg::*;
#(
   parameter int PERSIST_TICKS  = 2048,
   parameter int DEBOUNCE_TICKS = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        clk_en,
   input  logic [7:0]  pa_o,
   input  logic [7:0]  pa_oe,
   input  logic [7:0]  pb_o,
   input  logic [7:0]  pb_oe,
   output logic [7:0]  pa_i,
   input  logic        key_down,
   input  logic [4:0]  key_idx,
   input  logic        tty_rx,
   output logic [41:0] seg_o,
   output logic [5:0]  digit_on_o
);

   localparam int PW = $clog2(PERSIST_TICKS + 1);
   localparam logic [PW-1:0] PERSIST_LOAD = PW'(PERSIST_TICKS);

   logic [3:0] sel;
   logic       dig_hit;
   logic [2:0] dig_idx;
   logic [6:0] strobe_seg;

   logic [NUM_DIGITS-1:0][6:0]    seg_q, seg_d;
   logic [NUM_DIGITS-1:0]         on_q, on_d;
   logic [NUM_DIGITS-1:0][PW-1:0] cnt_q, cnt_d;
   logic [6:0]                    keys_n_q, keys_n_d;
   logic                          tty_bit;

   logic       key_held;
   logic [1:0] key_row_w;
   logic [2:0] key_col_w;

   logic unused_port_bits;
   assign unused_port_bits = ^{pb_o[7:5], pb_o[0], pb_oe[7:5], pb_oe[0], pa_o[7], pa_oe[7]};

   always_comb begin
      sel        = (pb_oe[4:1] == 4'hF) ? pb_o[4:1] : SEL_NONE;
      dig_hit    = (sel >= DIGIT_BASE) && (sel < DIGIT_BASE + 4'(NUM_DIGITS));
      dig_idx    = 3'(sel - DIGIT_BASE);
      strobe_seg = pa_o[6:0] & pa_oe[6:0];
   end

   // A non-blank strobe wins over expiry; blank strobes fall through to the countdown.
   always_comb begin
      seg_d = seg_q;
      on_d  = on_q;
      cnt_d = cnt_q;
      if (clk_en) begin
         for (int d = 0; d < NUM_DIGITS; d++) begin
            if (dig_hit && (dig_idx == 3'(d)) && (strobe_seg != 7'd0)) begin
               seg_d[d] = strobe_seg;
               on_d[d]  = 1'b1;
               cnt_d[d] = PERSIST_LOAD;
            end else if (cnt_q[d] != '0) begin
               cnt_d[d] = cnt_q[d] - PW'(1);
               if (cnt_q[d] == PW'(1)) begin
                  on_d[d]  = 1'b0;
                  seg_d[d] = 7'd0;
               end
            end
         end
      end
   end

   always_comb begin
      keys_n_d = 7'h7F;
      if (key_held && (sel < 4'(NUM_ROWS)) && (sel[1:0] == key_row_w))
         keys_n_d[key_col_w] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         seg_q    <= '0;
         on_q     <= '0;
         cnt_q    <= '0;
         keys_n_q <= 7'h7F;
      end else begin
         seg_q    <= seg_d;
         on_q     <= on_d;
         cnt_q    <= cnt_d;
         keys_n_q <= keys_n_d;
      end
   end

`ifdef KIM1_TTY_EN
   logic tty_s1_q, tty_s1_d, tty_s2_q, tty_s2_d;

   always_comb begin
      tty_s1_d = tty_rx;
      tty_s2_d = tty_s1_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tty_s1_q <= 1'b1;
         tty_s2_q <= 1'b1;
      end else begin
         tty_s1_q <= tty_s1_d;
         tty_s2_q <= tty_s2_d;
      end
   end

   assign tty_bit = tty_s2_q;
`else
   logic unused_tty;
   assign unused_tty = tty_rx;
   assign tty_bit    = 1'b1;
`endif

   kim1_key_debounce #(
      .DEBOUNCE_TICKS(DEBOUNCE_TICKS)
   ) u_debounce (
      .clk     (clk),
      .rst_n   (rst_n),
      .clk_en  (clk_en),
      .key_down(key_down),
      .key_idx (key_idx),
      .held    (key_held),
      .row     (key_row_w),
      .col     (key_col_w)
   );

   assign seg_o      = seg_q;
   assign digit_on_o = on_q;
   assign pa_i       = {tty_bit, keys_n_q};

endmodule

// File: tb/tb_kim1_display_keypad.sv
// Self-checking bench: directed steps then random traffic, compared each cycle
// against a tick-timestamp display model and a stability-based key model.
`timescale 1ns/1ps
module tb_kim1_display_keypad;

   localparam int PT = 4;
   localparam int DT = 16;

   logic        clk = 1'b0;
   logic        rst_n, clk_en, key_down, tty_rx;
   logic [7:0]  pa_o, pa_oe, pb_o, pb_oe, pa_i;
   logic [4:0]  key_idx;
   logic [41:0] seg_o;
   logic [5:0]  digit_on_o;

   always #5 clk = ~clk;

   kim1_display_keypad #(.PERSIST_TICKS(PT), .DEBOUNCE_TICKS(DT)) dut (
      .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
      .pa_o(pa_o), .pa_oe(pa_oe), .pb_o(pb_o), .pb_oe(pb_oe), .pa_i(pa_i),
      .key_down(key_down), .key_idx(key_idx), .tty_rx(tty_rx),
      .seg_o(seg_o), .digit_on_o(digit_on_o)
   );

   int checks = 0;
   int errors = 0;

   // Display model: a digit is lit while fewer than PT ticks have passed since its last load.
   int         tick_n;
   int         last_t[6];
   logic [6:0] seg_m[6];
   bit         lit_m[6];
   // Key model: -1 means released; a value is accepted once stable for DT ticks.
   int         key_seen, key_acc, stable_n;
   bit         pend;
   logic [7:0] pa_m;
   logic       tty1_m, tty2_m;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      tick_n = 0;
      for (int d = 0; d < 6; d++) begin
         last_t[d] = 0; seg_m[d] = 7'd0; lit_m[d] = 1'b0;
      end
      key_seen = -1; key_acc = -1; stable_n = 0; pend = 1'b0;
      pa_m = 8'hFF; tty1_m = 1'b1; tty2_m = 1'b1;
   endtask

   task automatic cyc();
      int          sel, cur;
      logic [6:0]  s, kb;
      logic [41:0] seg_e;
      logic [5:0]  on_e;
      @(posedge clk);
      sel = (pb_oe[4:1] == 4'hF) ? int'(pb_o[4:1]) : 15;
      s   = pa_o[6:0] & pa_oe[6:0];
      if (!rst_n) begin
         model_reset();
      end else begin
         kb = 7'h7F;
         if (key_acc >= 0 && sel <= 2 && sel == key_acc / 7) kb[key_acc % 7] = 1'b0;
         pa_m[6:0] = kb;
`ifdef KIM1_TTY_EN
         tty2_m = tty1_m;
         tty1_m = tty_rx;
         pa_m[7] = tty2_m;
`else
         pa_m[7] = 1'b1;
`endif
         cur = (key_down && key_idx < 5'd21) ? int'(key_idx) : -1;
         if (cur != key_seen) begin
            key_seen = cur; pend = 1'b1; stable_n = 0;
         end else if (pend && clk_en) begin
            stable_n++;
            if (stable_n == DT) begin pend = 1'b0; key_acc = key_seen; end
         end
         if (clk_en) begin
            tick_n++;
            for (int d = 0; d < 6; d++) begin
               if (sel - 4 == d && s != 7'd0) begin
                  seg_m[d] = s; lit_m[d] = 1'b1; last_t[d] = tick_n;
               end else if (lit_m[d] && tick_n - last_t[d] >= PT) begin
                  lit_m[d] = 1'b0; seg_m[d] = 7'd0;
               end
            end
         end
      end
      #1;
      for (int d = 0; d < 6; d++) begin
         seg_e[7*d +: 7] = seg_m[d];
         on_e[d]         = lit_m[d];
      end
      chk("model_seg", seg_o, seg_e);
      chk("model_on", digit_on_o, on_e);
      chk("model_pa", pa_i, pa_m);
   endtask

   task automatic setsel(input int sel);
      pb_oe = 8'h1E;
      pb_o  = 8'(sel << 1);
   endtask

   initial begin
      rst_n = 1'b0; clk_en = 1'b0; pa_o = 8'h00; pa_oe = 8'h00; pb_o = 8'h00; pb_oe = 8'h00;
      key_down = 1'b0; key_idx = 5'd0; tty_rx = 1'b1;
      model_reset();
      cyc(); cyc();
      chk("rst_seg", seg_o, 42'd0);
      chk("rst_on", digit_on_o, 6'd0);
      chk("rst_pa", pa_i, 8'hFF);
      rst_n = 1'b1;
      cyc();

      // Strobe digit 2
      pb_oe = 8'h1E; pb_o = 8'h0C; pa_oe = 8'h7F; pa_o = 8'h3F; clk_en = 1'b1;
      cyc();
      chk("strobe_seg2", seg_o[20:14], 7'h3F);
      chk("strobe_on", digit_on_o, 6'b000100);

      // Persistence on digit 0
      setsel(4); pa_o = 8'h5B; cyc();
      setsel(15);
      cyc(); cyc(); cyc();
      chk("persist_tick3_on", digit_on_o[0], 1'b1);
      cyc();
      chk("persist_tick4_on", digit_on_o[0], 1'b0);
      chk("persist_tick4_seg", seg_o[6:0], 7'h00);

      // Blank strobe must not refresh digit 5
      setsel(9); pa_o = 8'h06; cyc();
      setsel(15); cyc(); cyc();
      setsel(9); pa_o = 8'h00; cyc();
      chk("blank_seg5", seg_o[41:35], 7'h06);
      chk("blank_on5", digit_on_o[5], 1'b1);
      setsel(15); cyc();
      chk("blank_expire_on5", digit_on_o[5], 1'b0);
      chk("blank_expire_seg5", seg_o[41:35], 7'h00);

      // Debounce key 9 (row 1, col 2)
      setsel(1); key_down = 1'b1; key_idx = 5'd9;
      repeat (10) cyc();
      chk("db_early", pa_i[6:0], 7'h7F);
      repeat (10) cyc();
      chk("db_row1", pa_i[6:0], 7'h7B);
      setsel(0); cyc();
      chk("db_row0", pa_i[6:0], 7'h7F);

      // Key change while held keeps old key until resolved
      setsel(1); key_idx = 5'd3;
      repeat (5) cyc();
      chk("held_keep", pa_i[6:0], 7'h7B);
      repeat (15) cyc();
      chk("held_new_row1", pa_i[6:0], 7'h7F);
      setsel(0); cyc();
      chk("held_new_row0", pa_i[6:0], 7'h77);

      // Out-of-range index acts as release
      key_idx = 5'd25;
      repeat (20) cyc();
      chk("idx_oob", pa_i[6:0], 7'h7F);

      // Bounce never accepted
      key_down = 1'b0; repeat (20) cyc();
      key_idx = 5'd9; setsel(1);
      for (int t = 0; t < 40; t++) begin
         if (t % 5 == 0) key_down = ~key_down;
         cyc();
         chk("bounce", pa_i[6:0], 7'h7F);
      end

      // Reset with digits lit and key held
      key_down = 1'b1; repeat (20) cyc();
      setsel(5); pa_o = 8'h11; cyc();
      setsel(7); pa_o = 8'h22; cyc();
      setsel(1);
      rst_n = 1'b0; cyc();
      chk("rst_mid_seg", seg_o, 42'd0);
      chk("rst_mid_on", digit_on_o, 6'd0);
      chk("rst_mid_pa", pa_i, 8'hFF);
      rst_n = 1'b1;

      // Reset mid-debounce discards the pending key
      repeat (5) cyc();
      rst_n = 1'b0; cyc(); rst_n = 1'b1;
      repeat (12) cyc();
      chk("rst_discard", pa_i[6:0], 7'h7F);

      // Random traffic
      for (int i = 0; i < 600; i++) begin
         clk_en = ($urandom_range(0, 3) != 0);
         pb_oe  = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h1E;
         pb_o   = 8'($urandom);
         pa_oe  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
         pa_o   = ($urandom_range(0, 4) == 0) ? 8'h00 : 8'($urandom);
         if ($urandom_range(0, 40) == 0) begin
            key_down = 1'($urandom_range(0, 1));
            key_idx  = 5'($urandom);
         end
         tty_rx = 1'($urandom_range(0, 1));
         rst_n  = ($urandom_range(0, 150) != 0);
         cyc();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/kim1_display_keypad.md
KIM1_DISPLAY_KEYPAD -- requirements
Module: kim1_display_keypad

Interface
REQ-001 SHALL have parameter PERSIST_TICKS, default 2048: clk_en ticks a digit stays lit after its last strobe.
REQ-002 SHALL have parameter DEBOUNCE_TICKS, default 16: clk_en ticks a key input must be stable before it is accepted.
REQ-003 SHALL have port clk, input, 1: system clock; all logic on posedge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have port clk_en, input, 1: phi2 tick; timers advance only on ticks.
REQ-006 SHALL have ports pa_o / pa_oe, input, 8 each: RRIOT port A output data / direction.
REQ-007 SHALL have ports pb_o / pb_oe, input, 8 each: RRIOT port B output data / direction.
REQ-008 SHALL have port pa_i, output, 8: port A input data returned to the RRIOT.
REQ-009 SHALL have ports key_down, input, 1, and key_idx, input, 5: host key state; key_idx 0..20 maps to row = idx/7, col = idx%7.
REQ-010 SHALL have port tty_rx, input, 1: serial line level.
REQ-011 SHALL have ports seg_o, output, 42 (digit d at bits [7d+6:7d]), and digit_on_o, output, 6: static display image.

Function
REQ-012 SHALL form the select code sel = pb_o[4:1] when pb_oe[4:1] == 4'hF, else sel = 4'hF (none).
REQ-013 SHALL treat sel 4..9 as display digit d = sel-4 and sel 0..2 as keypad row sel; all other codes select nothing.
REQ-014 SHALL take strobe segments s = pa_o[6:0] & pa_oe[6:0] for the selected digit on every clk_en.
REQ-015 SHALL, when a digit is selected and s != 0, load seg_o[d] <= s, set digit_on_o[d], and load that digit's persistence counter with PERSIST_TICKS, all in the same cycle.
REQ-016 SHALL ignore strobes with s == 0 (software blanking between digits); they SHALL neither load the digit nor refresh its counter.
REQ-017 SHALL decrement every nonzero, non-refreshed persistence counter by 1 per clk_en; on reaching 0 it SHALL clear digit_on_o[d] and seg_o[d] in the same cycle.
REQ-018 SHALL let a refresh and an expiry on the same tick resolve to refresh.
REQ-019 SHALL drive a registered pa_i with 1-cycle latency, updated every clk: bits[6:0] = 7'h7F, except bit col = 0 when a debounced key is held, sel equals its row, and sel is 0..2.
REQ-020 SHALL implement debounce as an FSM with states IDLE, PEND, and HELD.
REQ-021 SHALL have FSM behaviour: any change of {key_down, valid key_idx} enters PEND and clears the counter; DEBOUNCE_TICKS stable ticks in PEND enter HELD (key latched) if down, else IDLE; a change in PEND restarts the count.
REQ-022 SHALL treat key_idx >= 21 as key released.
REQ-023 SHALL let a change of key_idx while HELD enter PEND; the previously latched key SHALL remain reported until PEND resolves.

Reset
REQ-024 SHALL, while rst_n is low at posedge clk, clear seg_o, digit_on_o, and all counters, put the FSM in IDLE with no latched key, and set pa_i = 8'hFF.
REQ-025 SHALL give reset priority over clk_en, strobes, and key changes; reset mid-debounce SHALL discard the pending key.

Configuration
REQ-026 SHALL support macro KIM1_TTY_EN: when defined, tty_rx passes through a 2-flop synchronizer to pa_i[7] and reset sets that path to 1.
REQ-027 SHALL, when KIM1_TTY_EN is undefined, tie pa_i[7] to 1 and leave tty_rx unused.

Structure
REQ-028 SHALL place in shared package kim1_pkg: NUM_DIGITS=6, NUM_ROWS=3, NUM_COLS=7, DIGIT_BASE=4, the select-none code 4'hF, and the debounce state enum.
REQ-029 SHALL implement debounce in sub-module kim1_key_debounce, with outputs held and row/col; display persistence stays in the top.

Verification
REQ-030 SHALL verify strobe: pb_oe=8'h1E, pb_o[4:1]=6, pa_oe=8'h7F, pa_o=8'h3F, one clk_en -> seg_o digit 2 = 7'h3F, digit_on_o=6'b000100 next cycle.
REQ-031 SHALL verify persistence: PERSIST_TICKS=4, strobe digit 0 once, then 4 clk_en with no strobe -> digit_on_o[0] clears on the 4th tick and seg_o digit 0 = 0.
REQ-032 SHALL verify blanking: strobe digit 5 with pa_o=8'h00 after a 7'h06 load -> seg_o digit 5 stays 7'h06 and its counter is not refreshed.
REQ-033 SHALL verify debounce: DEBOUNCE_TICKS=16, key_down=1, key_idx=9, hold 16 ticks, sel=1 -> pa_i[6:0]=7'h7B; with sel=0 -> 7'h7F.
REQ-034 SHALL verify bounce: toggle key_down every 5 ticks for 40 ticks -> pa_i[6:0] stays 7'h7F throughout.
REQ-035 SHALL verify reset mid-operation: rst_n low for 1 clk with digits lit and a key held -> all outputs at reset values the next cycle.
